fixed_point_div_controller: RTL and testbench
=============================================

FIXED_POINT_DIV_CONTROLLER -- requirements
Module: fixed_point_div_controller

Interface
REQ-001 Parameter ITERS, default 14, quotient iterations per division.
REQ-002 Parameter CW, default 4, iteration counter width; CW SHALL satisfy 2^CW >= ITERS.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new division.
REQ-006 ack  input  1  consumer acknowledges the result or error.
REQ-007 dvz  input  1  datapath flag: registered divisor is zero.
REQ-008 gt  input  1  datapath flag: ACC >= B in the current iteration.
REQ-009 ov  input  1  datapath flag: quotient overflow.
REQ-010 ld_a, ld_b  output  1 each  load the operand registers.
REQ-011 acc_init  output  1  clear ACC and load Q from A.
REQ-012 shift_en  output  1  shift ACC:Q left by one.
REQ-013 sub_sel  output  1  write the subtractor result into ACC.
REQ-014 q_bit  output  1  quotient bit shifted into Q.
REQ-015 busy  output  1  division in progress.
REQ-016 result_valid  output  1  quotient is stable.
REQ-017 err_dvz, err_ov  output  1 each  sticky error flags.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, INIT, ITER, DONE and ERR.
REQ-019 IDLE: start=1 SHALL transition to LOAD; otherwise the FSM SHALL stay in IDLE.
REQ-020 LOAD (1 cycle): ld_a=ld_b=1; next state SHALL be INIT.
REQ-021 INIT (1 cycle): if dvz=1, the FSM SHALL go to ERR, set err_dvz, and keep acc_init=0; otherwise acc_init=1, counter cleared, next state ITER.
REQ-022 ITER: shift_en=1 every cycle; sub_sel=q_bit=gt in the same cycle (combinational); the counter SHALL increment.
REQ-023 ITER SHALL last exactly ITERS cycles; after the cycle with counter=ITERS-1, the next state SHALL be DONE.
REQ-024 ov=1 in any ITER cycle SHALL set err_ov and transition to ERR; it SHALL take priority over the last-iteration exit.
REQ-025 Latency: with start sampled at edge 0, LOAD SHALL occupy cycle 1, INIT cycle 2, ITER cycles 3..ITERS+2, and result_valid SHALL rise in cycle ITERS+3 (17 at default).
REQ-026 busy SHALL be 1 in LOAD, INIT and ITER only.
REQ-027 DONE: result_valid=1 SHALL hold until ack=1; ack alone SHALL return the FSM to IDLE.
REQ-028 DONE with ack=1 and start=1 in the same cycle SHALL go directly to LOAD (back-to-back operation).
REQ-029 ERR: error flags SHALL hold and result_valid=0; ack SHALL clear both flags and return to IDLE; ack+start SHALL go to LOAD.
REQ-030 start while busy=1 SHALL be ignored, with no queuing.
REQ-031 ack outside DONE/ERR SHALL be ignored.
REQ-032 All datapath strobes SHALL be mutually consistent: ld_* never coincides with acc_init or shift_en.

Reset
REQ-033 rst=1 at an edge SHALL force IDLE, counter=0, and all outputs 0 from the next cycle, from any state, including mid-ITER.
REQ-034 rst SHALL take priority over start, ack and all datapath flags.

Structure
REQ-035 The state enum, ITERS default and CW default SHALL live in the shared package fpdiv_pkg.
REQ-036 The iteration counter SHALL be one sub-module, fpdiv_iter_counter (clear, enable, terminal-count output).
REQ-037 The FSM state SHALL be registered; strobe outputs SHALL be decoded combinationally from state and flags; result_valid and the err_* flags SHALL be registered.

Verification
REQ-038 Normal division: start pulse, dvz=0, ov=0, gt toggling 1,0,1,0... -> ld_* in cycle 1, acc_init in cycle 2, 14 shift_en cycles, q_bit mirrors gt, result_valid in cycle 17, busy=0 from cycle 17.
REQ-039 Zero divisor: start, dvz=1 in cycle 2 -> acc_init stays 0, err_dvz=1 from cycle 3, no shift_en; ack -> IDLE with flags cleared.
REQ-040 Overflow: ov=1 in the 5th ITER cycle -> err_ov=1 next cycle, shift_en stops, result_valid never asserts.
REQ-041 Back-to-back: in DONE, ack=1 and start=1 together -> result_valid drops and ld_a=ld_b=1 the next cycle.
REQ-042 Reset mid-operation: rst in the 7th ITER cycle -> all outputs 0 next cycle; a new start then yields the full 17-cycle latency.
REQ-043 start held high throughout ITER -> no restart; exactly 14 shift_en pulses occur.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared types and defaults for the fixed-point divider controller
package fpdiv_pkg;

    localparam int ITERS_DEFAULT = 14;
    localparam int CW_DEFAULT    = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        INIT = 3'd2,
        ITER = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/fixed_point_div_controller_if.sv
// rtl/fixed_point_div_controller_if.sv - handshake, datapath flag and strobe bundle
interface fixed_point_div_controller_if;

    logic start;
    logic ack;
    logic dvz;
    logic gt;
    logic ov;
    logic ld_a;
    logic ld_b;
    logic acc_init;
    logic shift_en;
    logic sub_sel;
    logic q_bit;
    logic busy;
    logic result_valid;
    logic err_dvz;
    logic err_ov;

    modport master (
        output start, ack, dvz, gt, ov,
        input  ld_a, ld_b, acc_init, shift_en, sub_sel, q_bit,
        input  busy, result_valid, err_dvz, err_ov
    );

    modport slave (
        input  start, ack, dvz, gt, ov,
        output ld_a, ld_b, acc_init, shift_en, sub_sel, q_bit,
        output busy, result_valid, err_dvz, err_ov
    );

endinterface

// File: rtl/fpdiv_iter_counter.sv
// rtl/fpdiv_iter_counter.sv - quotient iteration counter with terminal-count flag
module fpdiv_iter_counter #(
    parameter int ITERS = 14,
    parameter int CW    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);

    logic [CW-1:0] count;

    // Count iterations; cleared before each division so ITER always starts at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == LAST_COUNT);

endmodule

// File: rtl/fixed_point_div_controller.sv
// rtl/fixed_point_div_controller.sv - restoring-division sequencer FSM
module fixed_point_div_controller
    import fpdiv_pkg::*;
#(
    parameter int ITERS = ITERS_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input logic                         clk,
    input logic                         rst,
    fixed_point_div_controller_if.slave bus
);

    state_t state;
    logic   rv_q;
    logic   err_dvz_q;
    logic   err_ov_q;
    logic   cnt_last;

    fpdiv_iter_counter #(
        .ITERS (ITERS),
        .CW    (CW)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state == INIT),
        .en    (state == ITER),
        .last  (cnt_last)
    );

    // Sequencer: overflow beats the last-iteration exit; ack+start in DONE/ERR chains straight into LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rv_q      <= 1'b0;
            err_dvz_q <= 1'b0;
            err_ov_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) state <= LOAD;
                LOAD: state <= INIT;
                INIT: begin
                    if (bus.dvz) begin
                        state     <= ERR;
                        err_dvz_q <= 1'b1;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (bus.ov) begin
                        state    <= ERR;
                        err_ov_q <= 1'b1;
                    end else if (cnt_last) begin
                        state <= DONE;
                        rv_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        rv_q  <= 1'b0;
                        state <= bus.start ? LOAD : IDLE;
                    end
                end
                ERR: begin
                    if (bus.ack) begin
                        err_dvz_q <= 1'b0;
                        err_ov_q  <= 1'b0;
                        state     <= bus.start ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath strobes decode directly from the state so q_bit follows gt within the cycle.
    assign bus.ld_a         = (state == LOAD);
    assign bus.ld_b         = (state == LOAD);
    assign bus.acc_init     = (state == INIT) && !bus.dvz;
    assign bus.shift_en     = (state == ITER);
    assign bus.sub_sel      = (state == ITER) && bus.gt;
    assign bus.q_bit        = (state == ITER) && bus.gt;
    assign bus.busy         = (state == LOAD) || (state == INIT) || (state == ITER);
    assign bus.result_valid = rv_q;
    assign bus.err_dvz      = err_dvz_q;
    assign bus.err_ov       = err_ov_q;

endmodule

// File: tb/tb_fixed_point_div_controller.sv
// tb/tb_fixed_point_div_controller.sv - randomized self-checking bench for the divider controller
module tb_fixed_point_div_controller;

    localparam int ITERS = 14;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fixed_point_div_controller_if bus ();

    fixed_point_div_controller #(
        .ITERS (ITERS),
        .CW    (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {ld_a, ld_b, acc_init, shift_en, sub_sel, q_bit, busy, result_valid, err_dvz, err_ov}
    function automatic logic [9:0] observed();
        return {bus.ld_a, bus.ld_b, bus.acc_init, bus.shift_en, bus.sub_sel,
                bus.q_bit, bus.busy, bus.result_valid, bus.err_dvz, bus.err_ov};
    endfunction

    // Expected outputs c cycles after start was sampled, from the timeline of a division.
    function automatic logic [9:0] model(int c, bit dz, int ovat, bit g);
        int i;
        i = c - 2;
        if (c == 1) return 10'b1100001000;
        if (c == 2) return dz ? 10'b0000001000 : 10'b0010001000;
        if (dz) return 10'b0000000010;
        if (ovat != 0 && i > ovat) return 10'b0000000001;
        if (i <= ITERS) return {3'b000, 1'b1, g, g, 1'b1, 3'b000};
        return 10'b0000000100;
    endfunction

    function automatic bit waiting(int c, bit dz, int ovat);
        if (c <= 2) return 1'b0;
        if (dz) return 1'b1;
        if (ovat != 0 && c - 2 > ovat) return 1'b1;
        return (c - 2 > ITERS);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_division(input string name, input bit dz, input int ovat, input bit hold_start,
                                input bit noise, input int rst_at, input bit b2b, input bit skip_start,
                                output int shifts);
        logic [9:0] exp_v;
        logic [9:0] got;
        bit g;
        shifts = 0;
        if (!skip_start) begin
            bus.start = 1'b1; bus.ack = 1'b0; bus.dvz = 1'b0; bus.gt = 1'b0; bus.ov = 1'b0;
            next_cycle();
        end
        for (int c = 1; c <= ITERS + 3; c++) begin
            g = 1'($urandom);
            bus.start = hold_start ? 1'b1 : 1'($urandom);
            if (c >= ITERS) bus.start = hold_start;
            bus.dvz = dz;
            bus.gt  = g;
            bus.ov  = (ovat != 0 && c == ovat + 2);
            bus.ack = (noise && !waiting(c, dz, ovat)) ? 1'($urandom) : 1'b0;
            if (waiting(c, dz, ovat)) bus.start = hold_start;
            rst = (c == rst_at);
            if (c == rst_at) begin bus.start = 1'b1; bus.ack = 1'b1; end
            @(negedge clk);
            got   = observed();
            exp_v = model(c, dz, ovat, g);
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL %s cycle=%0d got=%b exp=%b", name, c, got, exp_v);
            end
            shifts += int'(got[6]);
            next_cycle();
            if (c == rst_at) begin
                rst = 1'b0; bus.start = 1'b0; bus.ack = 1'b0; bus.ov = 1'b0; bus.dvz = 1'b0;
                @(negedge clk);
                total++;
                if (observed() !== 10'b0) begin
                    bad++;
                    $display("FAIL %s_reset got=%b exp=%b", name, observed(), 10'b0);
                end
                next_cycle();
                return;
            end
        end
        // Still parked in DONE/ERR; now acknowledge.
        g = 1'($urandom);
        bus.ack = 1'b1; bus.start = b2b; bus.gt = g; bus.ov = 1'b0; bus.dvz = 1'b0;
        @(negedge clk);
        exp_v = model(ITERS + 4, dz, ovat, g);
        total++;
        if (observed() !== exp_v) begin
            bad++;
            $display("FAIL %s_park got=%b exp=%b", name, observed(), exp_v);
        end
        next_cycle();
        bus.ack = 1'b0; bus.start = 1'b0;
        if (b2b) return;
        @(negedge clk);
        total++;
        if (observed() !== 10'b0) begin
            bad++;
            $display("FAIL %s_ack got=%b exp=%b", name, observed(), 10'b0);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.ack = 1'b1; bus.dvz = 1'b1; bus.gt = 1'b1; bus.ov = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (observed() !== 10'b0) begin
            bad++;
            $display("FAIL reset got=%b exp=%b", observed(), 10'b0);
        end
        rst = 1'b0; bus.start = 1'b0; bus.ack = 1'b0; bus.dvz = 1'b0; bus.gt = 1'b0; bus.ov = 1'b0;
        next_cycle();
    endtask

    task automatic test_idle_ack();
        bus.ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (observed() !== 10'b0) begin
                bad++;
                $display("FAIL idle_ack got=%b exp=%b", observed(), 10'b0);
            end
            next_cycle();
        end
        bus.ack = 1'b0;
    endtask

    task automatic test_normal();
        int s;
        run_division("normal", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, s);
        total++;
        if (s !== ITERS) begin
            bad++;
            $display("FAIL normal_shifts got=%0d exp=%0d", s, ITERS);
        end
    endtask

    task automatic test_zero_divisor();
        int s;
        run_division("dvz", 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, s);
        total++;
        if (s !== 0) begin
            bad++;
            $display("FAIL dvz_shifts got=%0d exp=0", s);
        end
    endtask

    task automatic test_overflow();
        int s;
        run_division("ov5", 1'b0, 5, 1'b0, 1'b0, 0, 1'b0, 1'b0, s);
        total++;
        if (s !== 5) begin
            bad++;
            $display("FAIL ov5_shifts got=%0d exp=5", s);
        end
        run_division("ov_last", 1'b0, ITERS, 1'b0, 1'b0, 0, 1'b0, 1'b0, s);
    endtask

    task automatic test_back_to_back();
        int s;
        run_division("b2b_first", 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, s);
        run_division("b2b_second", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, s);
        run_division("b2b_err", 1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, s);
        run_division("b2b_after_err", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, s);
    endtask

    task automatic test_reset_mid_iter();
        int s;
        run_division("rst_mid", 1'b0, 0, 1'b0, 1'b0, 9, 1'b0, 1'b0, s);
        run_division("after_rst", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, s);
    endtask

    task automatic test_start_held();
        int s;
        run_division("start_held", 1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, s);
        total++;
        if (s !== ITERS) begin
            bad++;
            $display("FAIL start_held_shifts got=%0d exp=%0d", s, ITERS);
        end
    endtask

    task automatic test_random();
        int s;
        bit dz;
        int ovat;
        for (int k = 0; k < 12; k++) begin
            dz   = ($urandom_range(0, 4) == 0);
            ovat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ITERS)) : 0;
            run_division("random", dz, ovat, 1'($urandom), 1'b1, 0, 1'b0, 1'b0, s);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.ack = 1'b0; bus.dvz = 1'b0; bus.gt = 1'b0; bus.ov = 1'b0;
        test_reset();
        test_idle_ack();
        test_normal();
        test_zero_divisor();
        test_overflow();
        test_back_to_back();
        test_reset_mid_iter();
        test_start_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
